// File: rtl/ram_pipe_if.sv
// ram_pipe_if -- request/response bundle for the ram_pipe single-port memory.
//
// Signals
//   EN         : operation request for this cycle (requester -> memory)
//   WR         : 1 = write, 0 = read, qualified by EN
//   Address    : word address
//   Data_in    : write data
//   Byte_en    : per-byte write enable, bit i covers Data_in[8i+7:8i]
//   Data_out   : read data (memory -> requester)
//   Valid_out  : one-cycle strobe qualifying Data_out
//   Err_out    : out-of-range flag, only ever high together with Valid_out
//
// Handshake: EN acts as a valid with an implicit, permanently asserted ready.
// The memory takes one operation on every rising edge where EN=1 and never
// stalls. Valid_out is a valid without a ready: the requester must take the
// response in the single cycle it is presented, because nothing holds it.
//
// Modports
//   master : the requester side (drives EN/WR/Address/Data_in/Byte_en)
//   slave  : the memory side (drives Data_out/Valid_out/Err_out)

interface ram_pipe_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic                    EN;
    logic                    WR;
    logic [ADDR_WIDTH-1:0]   Address;
    logic [DATA_WIDTH-1:0]   Data_in;
    logic [DATA_WIDTH/8-1:0] Byte_en;
    logic [DATA_WIDTH-1:0]   Data_out;
    logic                    Valid_out;
    logic                    Err_out;

    modport master (
        output EN,
        output WR,
        output Address,
        output Data_in,
        output Byte_en,
        input  Data_out,
        input  Valid_out,
        input  Err_out
    );

    modport slave (
        input  EN,
        input  WR,
        input  Address,
        input  Data_in,
        input  Byte_en,
        output Data_out,
        output Valid_out,
        output Err_out
    );
endinterface

// File: rtl/ram_pipe.sv
// ram_pipe -- single-port word memory with byte-enabled writes and a fully
// pipelined read path of configurable latency.
//
// Parameters
//   ADDR_WIDTH   : address bus width
//   ADDR_DEPTH   : implemented words, 1..2**ADDR_WIDTH
//   DATA_WIDTH   : word width, multiple of 8
//   READ_LATENCY : cycles from read request to Valid_out, 1..4
//
// Ports
//   clk  : single clock, all state on its rising edge
//   rst  : asynchronous, active-low reset (clears the read pipeline only)
//   bus  : ram_pipe_if.slave request/response bundle
//
// Behaviour summary
//   - One operation per EN=1 cycle, no stalls.
//   - Writes update only the enabled bytes; out-of-range writes vanish.
//   - A read issued in cycle c returns in cycle c+READ_LATENCY with
//     Valid_out=1; out-of-range reads return zero data with Err_out=1.
//   - A read sees every write issued in an earlier cycle, because the array
//     is read combinationally at the same edge that captures stage 1.
//   - Memory contents survive reset; in-flight reads are discarded.

module ram_pipe #(
    parameter int ADDR_WIDTH   = 4,
    parameter int ADDR_DEPTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    ram_pipe_if.slave  bus
);

    localparam int NB = DATA_WIDTH / 8;

    // Depth held one bit wider than the address so that a full
    // 2**ADDR_WIDTH depth is still representable in the comparison.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  in_range;
    logic                  rd_go;
    logic                  wr_go;
    logic [DATA_WIDTH-1:0] rd_word;

    logic [DATA_WIDTH-1:0] mem_q [ADDR_DEPTH];

    always_comb begin
        in_range = ({1'b0, bus.Address} < DEPTH_L);
        rd_go    = bus.EN & ~bus.WR;
        wr_go    = bus.EN & bus.WR & in_range;
        // Out-of-range reads must return zero, never a wrapped word.
        rd_word  = '0;
        if (in_range) begin
            rd_word = mem_q[bus.Address];
        end
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    // Shares the reset pin with the pipeline so that writes presented while
    // rst=0 are ignored, but the contents themselves are never cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // contents deliberately retained across reset
        end else if (wr_go) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.Byte_en[b]) begin
                    mem_q[bus.Address][8*b +: 8] <= bus.Data_in[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    // Stage 0 captures the addressed word; later stages are plain delays.
    // The error bit is only ever set together with the valid bit, so the
    // output flag is automatically 0 whenever Valid_out is 0. Data registers
    // load only on a valid entry, so Data_out holds between responses.
    logic                  vld_q [READ_LATENCY];
    logic                  vld_d [READ_LATENCY];
    logic                  err_q [READ_LATENCY];
    logic                  err_d [READ_LATENCY];
    logic [DATA_WIDTH-1:0] dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0] dat_d [READ_LATENCY];

    always_comb begin
        for (int i = 0; i < READ_LATENCY; i++) begin
            vld_d[i] = 1'b0;
            err_d[i] = 1'b0;
            dat_d[i] = dat_q[i];
        end

        vld_d[0] = rd_go;
        err_d[0] = rd_go & ~in_range;
        if (rd_go) begin
            dat_d[0] = rd_word;
        end

        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            if (vld_q[i-1]) begin
                dat_d[i] = dat_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                err_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_d[i];
                err_q[i] <= err_d[i];
                dat_q[i] <= dat_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the last stage
    // ------------------------------------------------------------------
    assign bus.Valid_out = vld_q[READ_LATENCY-1];
    assign bus.Err_out   = err_q[READ_LATENCY-1];
    assign bus.Data_out  = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_ram_pipe.sv
// tb_ram_pipe -- drives three ram_pipe instances with identical stimulus:
//   inst 0 : ADDR_DEPTH=16, READ_LATENCY=1
//   inst 1 : ADDR_DEPTH=12, READ_LATENCY=3
//   inst 2 : ADDR_DEPTH=12, READ_LATENCY=4
// A reference memory per instance predicts each read at issue time and
// queues {due cycle, err, data}; a per-instance monitor on the falling edge
// pops and compares, and otherwise expects an idle, holding output.

module tb_ram_pipe;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam int NI = 3;
    localparam int EW = 16 + 1 + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared stimulus ----------------
    logic          en   = 1'b0;
    logic          wr   = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din  = '0;
    logic [NB-1:0] be   = '0;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_m [NI][16];
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];

    function automatic int dep(int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic void sb_push(int k, logic [EW-1:0] v);
        case (k)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endfunction

    function automatic int sb_size(int k);
        case (k)
            0: return exp_q0.size();
            1: return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    function automatic logic [EW-1:0] sb_front(int k);
        case (k)
            0: return exp_q0[0];
            1: return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    function automatic void sb_pop(int k);
        case (k)
            0: void'(exp_q0.pop_front());
            1: void'(exp_q1.pop_front());
            default: void'(exp_q2.pop_front());
        endcase
    endfunction

    function automatic void sb_clear();
        exp_q0.delete();
        exp_q1.delete();
        exp_q2.delete();
    endfunction

    function automatic void chk(string name, int k, bit ok, logic [63:0] got, logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", name, k, cyc, got, exp);
        end
    endfunction

    // ---------------- DUTs and monitors ----------------
    for (genvar k = 0; k < NI; k++) begin : g
        ram_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

        assign bus.EN      = en;
        assign bus.WR      = wr;
        assign bus.Address = addr;
        assign bus.Data_in = din;
        assign bus.Byte_en = be;

        ram_pipe #(
            .ADDR_WIDTH  (AW),
            .ADDR_DEPTH  ((k == 0) ? 16 : 12),
            .DATA_WIDTH  (DW),
            .READ_LATENCY((k == 0) ? 1 : ((k == 1) ? 3 : 4))
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );

        logic [DW-1:0] last_d = '0;
        logic [EW-1:0] f;
        logic [33:0]   got;

        always @(negedge clk) begin
            if (mon_on) begin
                got = {bus.Valid_out, bus.Err_out, bus.Data_out};
                if (!rst) begin
                    chk("reset_outputs", k, got == 34'd0, 64'(got), 64'd0);
                    last_d = '0;
                end else begin
                    f = (sb_size(k) != 0) ? sb_front(k) : '0;
                    if (sb_size(k) != 0 && f[EW-1 -: 16] == 16'(cyc)) begin
                        chk("read_response", k, got == {1'b1, f[DW], f[DW-1:0]},
                            64'(got), 64'({1'b1, f[DW], f[DW-1:0]}));
                        last_d = f[DW-1:0];
                        sb_pop(k);
                    end else begin
                        chk("idle_hold", k, got == {2'b00, last_d},
                            64'(got), 64'({2'b00, last_d}));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive one cycle's inputs now; the DUT samples them at the next edge.
    task automatic op_now(bit e, bit w, int a, logic [DW-1:0] d, logic [NB-1:0] b);
        en   = e;
        wr   = w;
        addr = AW'(a);
        din  = d;
        be   = b;
        if (rst && e) begin
            for (int k = 0; k < NI; k++) begin
                if (w) begin
                    if (a < dep(k)) begin
                        for (int i = 0; i < NB; i++) begin
                            if (b[i]) mem_m[k][addr][8*i +: 8] = d[8*i +: 8];
                        end
                    end
                end else begin
                    sb_push(k, {16'(cyc + lat(k)), (a >= dep(k)),
                                (a < dep(k)) ? mem_m[k][addr] : 32'h0});
                end
            end
        end
    endtask

    task automatic op(bit e, bit w, int a, logic [DW-1:0] d, logic [NB-1:0] b);
        @(posedge clk);
        #1;
        op_now(e, w, a, d, b);
    endtask

    task automatic idle(int n);
        repeat (n) op(1'b0, 1'b0, 0, '0, '0);
    endtask

    // Assert reset with a write still presented (must be ignored), check the
    // outputs clear at once, hold, then release with a read on the same slot.
    task automatic reset_pulse(int hold);
        @(posedge clk);
        #1;
        rst = 1'b0;
        en = 1'b1; wr = 1'b1; addr = 4'd3; din = 32'hBAD0BAD0; be = 4'hF;
        sb_clear();
        #1;
        chk("async_clear", 0, {g[0].bus.Valid_out, g[0].bus.Err_out, g[0].bus.Data_out} == 34'd0,
            64'({g[0].bus.Valid_out, g[0].bus.Err_out, g[0].bus.Data_out}), 64'd0);
        chk("async_clear", 1, {g[1].bus.Valid_out, g[1].bus.Err_out, g[1].bus.Data_out} == 34'd0,
            64'({g[1].bus.Valid_out, g[1].bus.Err_out, g[1].bus.Data_out}), 64'd0);
        chk("async_clear", 2, {g[2].bus.Valid_out, g[2].bus.Err_out, g[2].bus.Data_out} == 34'd0,
            64'({g[2].bus.Valid_out, g[2].bus.Err_out, g[2].bus.Data_out}), 64'd0);
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b1;
        op_now(1'b1, 1'b0, 5, '0, '0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #1;
        rst    = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // known contents everywhere
        for (int a = 0; a < 16; a++) op(1'b1, 1'b1, a, $urandom, 4'hF);

        // basic write / read
        op(1'b1, 1'b1, 3, 32'hDEADBEEF, 4'hF);
        op(1'b1, 1'b0, 3, '0, '0);
        idle(2);

        // byte enables
        op(1'b1, 1'b1, 5, 32'h11223344, 4'hF);
        op(1'b1, 1'b1, 5, 32'hAABBCCDD, 4'b0101);
        op(1'b1, 1'b0, 5, '0, '0);

        // write then read in the very next cycle
        op(1'b1, 1'b1, 7, 32'h5, 4'hF);
        op(1'b1, 1'b0, 7, '0, '0);

        // back-to-back reads
        op(1'b1, 1'b0, 0, '0, '0);
        op(1'b1, 1'b0, 1, '0, '0);
        op(1'b1, 1'b0, 2, '0, '0);

        // write with no byte enabled
        op(1'b1, 1'b1, 2, 32'hFFFFFFFF, 4'h0);
        op(1'b1, 1'b0, 2, '0, '0);
        idle(5);

        // out-of-range write and read, then all in-range words and boundaries
        op(1'b1, 1'b1, 13, 32'hFFFFFFFF, 4'hF);
        op(1'b1, 1'b0, 13, '0, '0);
        for (int a = 0; a < 12; a++) op(1'b1, 1'b0, a, '0, '0);
        op(1'b1, 1'b0, 12, '0, '0);
        op(1'b1, 1'b0, 15, '0, '0);
        idle(6);

        // randomized traffic
        repeat (400) begin
            op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        end
        idle(6);

        // reset two cycles after a read is issued
        op(1'b1, 1'b0, 3, '0, '0);
        idle(1);
        reset_pulse(2);
        idle(8);

        // contents survived the reset
        for (int a = 0; a < 16; a++) op(1'b1, 1'b0, a, '0, '0);
        idle(8);

        mon_on = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk("queue_drained", k, sb_size(k) == 0, 64'(sb_size(k)), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_pipe.md
RAM_PIPE -- requirements
Module: ram_pipe

Interface
- REQ-001: The block SHALL have parameter ADDR_WIDTH, default 4, the address bus width.
- REQ-002: The block SHALL have parameter ADDR_DEPTH, default 16, the number of implemented words, legal range 1..2**ADDR_WIDTH.
- REQ-003: The block SHALL have parameter DATA_WIDTH, default 32, the word width, a multiple of 8.
- REQ-004: The block SHALL have parameter READ_LATENCY, default 1, the read latency in cycles, legal range 1..4.
- REQ-005: The block SHALL have input clk, 1 bit, the single clock; all state SHALL be on its rising edge.
- REQ-006: The block SHALL have input rst, 1 bit, the reset: asynchronous assertion, active-low.
- REQ-007: The block SHALL have input EN, 1 bit, the operation request for this cycle.
- REQ-008: The block SHALL have input WR, 1 bit; 1 selects a write and 0 a read, sampled only when EN=1.
- REQ-009: The block SHALL have input Address, ADDR_WIDTH bits, the word address.
- REQ-010: The block SHALL have input Data_in, DATA_WIDTH bits, the write data.
- REQ-011: The block SHALL have input Byte_en, DATA_WIDTH/8 bits, the per-byte write enable, where bit i covers Data_in[8i+7:8i].
- REQ-012: The block SHALL have output Data_out, DATA_WIDTH bits, the read data.
- REQ-013: The block SHALL have output Valid_out, 1 bit, a one-cycle strobe qualifying Data_out.
- REQ-014: The block SHALL have output Err_out, 1 bit, an out-of-range flag aligned with Valid_out.

Function
- REQ-015: The block SHALL accept one operation per cycle when EN=1, with no back-pressure and no stall.
- REQ-016: A write (EN=1, WR=1, Address<ADDR_DEPTH) SHALL update at the edge only the bytes whose Byte_en bit is 1; other bytes SHALL be unchanged.
- REQ-017: A write with Byte_en=0 SHALL leave memory unchanged.
- REQ-018: A write SHALL NOT assert Valid_out or Err_out.
- REQ-019: A read accepted at edge N SHALL present Data_out with Valid_out=1 after edge N+READ_LATENCY, for exactly one cycle.
- REQ-020: Reads SHALL be fully pipelined: back-to-back reads SHALL give back-to-back Valid_out, in request order.
- REQ-021: A read SHALL see all writes accepted at earlier edges, including a write one cycle before it to the same address.
- REQ-022: An out-of-range write (Address>=ADDR_DEPTH) SHALL be discarded with memory unchanged and no flag.
- REQ-023: An out-of-range read SHALL return Data_out=0, Valid_out=1, Err_out=1 with normal latency.
- REQ-024: In-range reads SHALL return Err_out=0.
- REQ-025: When Valid_out=0, Data_out SHALL hold its last value and Err_out SHALL be 0.
- REQ-026: Any cycle with EN=0 SHALL be idle, with no memory change and no pipeline entry inserted.
- REQ-027: Address wrap-around SHALL NOT occur; addresses at or above ADDR_DEPTH SHALL follow REQ-022 and REQ-023.
- REQ-028: Each read-pipeline stage SHALL carry a valid bit, an error bit and data; stage 1 SHALL capture the memory word, and stages 2..READ_LATENCY SHALL be registered delays.

Reset
- REQ-029: When rst=0, the block SHALL asynchronously clear Valid_out, Err_out, Data_out and all pipeline valid and error bits to 0.
- REQ-030: Reads in flight at reset assertion SHALL be dropped and SHALL never produce Valid_out.
- REQ-031: Memory contents SHALL NOT be altered by reset.
- REQ-032: Operations SHALL be ignored while rst=0.
- REQ-033: The first operation SHALL be accepted at the first rising edge with rst=1.

Verification
- REQ-034: The bench SHALL cover basic write/read: at READ_LATENCY=1, write 0xDEADBEEF to addr 3 with Byte_en=4'hF, then read addr 3 -> Valid_out=1 one cycle later, Data_out=0xDEADBEEF, Err_out=0.
- REQ-035: The bench SHALL cover byte enables: write 0x11223344 to addr 5 with Byte_en=F, then 0xAABBCCDD with Byte_en=4'b0101, then read addr 5 -> Data_out=0x11BB33DD.
- REQ-036: The bench SHALL cover pipelining: at READ_LATENCY=3, read addr 0,1,2 on consecutive cycles -> Valid_out high on three consecutive cycles starting 3 cycles after the first request, with data in order.
- REQ-037: The bench SHALL cover write-then-read: write 0x5 to addr 7 at edge N, read addr 7 at edge N+1 -> Data_out=0x5.
- REQ-038: The bench SHALL cover out-of-range access: with ADDR_DEPTH=12, write 0xFFFFFFFF to addr 13, then read addr 13 -> Data_out=0, Err_out=1, Valid_out=1, and memory words 0..11 unchanged.
- REQ-039: The bench SHALL cover reset mid-read: at READ_LATENCY=4, issue a read, assert rst=0 two cycles later -> outputs 0 immediately, no Valid_out after release, and memory still holds earlier written data.
